// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states, owner IDs,
// the legal RAM window and the RAM funct codes used by fetch and load/store.
package mem_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] MEM_TOP  = 32'h87FF_FFFF;

  // RAM funct codes: {funct3, opcode}
  localparam logic [9:0] FUNC_LB  = {3'b000, 7'b0000011};
  localparam logic [9:0] FUNC_LH  = {3'b001, 7'b0000011};
  localparam logic [9:0] FUNC_LW  = {3'b010, 7'b0000011};
  localparam logic [9:0] FUNC_LBU = {3'b100, 7'b0000011};
  localparam logic [9:0] FUNC_LHU = {3'b101, 7'b0000011};
  localparam logic [9:0] FUNC_SB  = {3'b000, 7'b0100011};
  localparam logic [9:0] FUNC_SH  = {3'b001, 7'b0100011};
  localparam logic [9:0] FUNC_SW  = {3'b010, 7'b0100011};

  typedef struct packed {
    owner_e      owner;
    logic        we;
    logic        fault;
    logic [9:0]  funct;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a < MEM_BASE) || (a > MEM_TOP);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store, with a saturating counter that
// forces a fetch grant after STARVE_MAX consecutive fetch losses (STARVE_MAX >= 1).
module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    grant_if = arb_en && if_valid && (!d_valid || (starve_q == SMAX));
    grant_d  = arb_en && d_valid && !grant_if;
    starve_d = starve_q;
    if (grant_if)
      starve_d = '0;
    else if (arb_en && if_valid && (starve_q != SMAX))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between fetch and load/store, one fixed-latency access
// at a time. Optional address window check: define MEM_ARB_ADDR_CHECK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_fault,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [9:0]  d_req_funct,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_fault,
  output logic        m_r_en,
  output logic        m_w_en,
  output logic [9:0]  m_funct,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] BEAT_INIT = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  acc_t        acc_q, acc_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] if_data_q, if_data_d, d_data_q, d_data_d;
  logic        if_flt_q, if_flt_d, d_flt_q, d_flt_d;
  logic        grant_if, grant_d, req_fault;
  logic [31:0] sel_addr, rsp_word;

  // Arbitration only happens in IDLE and never while reset is held
  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   ((state_q == ST_IDLE) && rst_n),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign sel_addr = grant_if ? if_req_addr : d_req_addr;
`ifdef MEM_ARB_ADDR_CHECK_EN
  assign req_fault = addr_bad(sel_addr);
`else
  assign req_fault = 1'b0;
`endif

  // Stores and faulting accesses report zero data
  assign rsp_word = (acc_q.we || acc_q.fault) ? 32'h0 : m_rdata;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    beat_d    = beat_q;
    if_data_d = if_data_q;
    if_flt_d  = if_flt_q;
    d_data_d  = d_data_q;
    d_flt_d   = d_flt_q;
    case (state_q)
      ST_IDLE: if (grant_if || grant_d) begin
        if (grant_if) begin
          acc_d.owner = OWN_IF;
          acc_d.funct = FUNC_LW;
          acc_d.we    = 1'b0;
          acc_d.wdata = 32'h0;
        end else begin
          acc_d.owner = OWN_D;
          acc_d.funct = d_req_funct;
          acc_d.we    = d_req_we;
          acc_d.wdata = d_req_wdata;
        end
        acc_d.addr  = sel_addr;
        acc_d.fault = req_fault;
        beat_d      = BEAT_INIT;
        state_d     = ST_BUSY;
      end
      ST_BUSY: if (beat_q == 4'd0) begin
        if (acc_q.owner == OWN_IF) begin
          if_data_d = rsp_word;
          if_flt_d  = acc_q.fault;
        end else begin
          d_data_d = rsp_word;
          d_flt_d  = acc_q.fault;
        end
        state_d = ST_RESP;
      end else begin
        beat_d = beat_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      beat_q    <= '0;
      if_data_q <= '0;
      if_flt_q  <= 1'b0;
      d_data_q  <= '0;
      d_flt_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      beat_q    <= beat_d;
      if_data_q <= if_data_d;
      if_flt_q  <= if_flt_d;
      d_data_q  <= d_data_d;
      d_flt_q   <= d_flt_d;
    end
  end

  // Write enable only in the first BUSY beat so each store is one RAM write
  always_comb begin
    m_r_en       = 1'b0;
    m_w_en       = 1'b0;
    m_funct      = '0;
    m_addr       = '0;
    m_wdata      = '0;
    if_rsp_valid = 1'b0;
    d_rsp_valid  = 1'b0;
    case (state_q)
      ST_BUSY: begin
        m_addr  = acc_q.addr;
        m_funct = acc_q.funct;
        m_wdata = acc_q.wdata;
        m_r_en  = !acc_q.we && !acc_q.fault;
        m_w_en  = acc_q.we && !acc_q.fault && (beat_q == BEAT_INIT);
      end
      ST_RESP: begin
        if_rsp_valid = (acc_q.owner == OWN_IF);
        d_rsp_valid  = (acc_q.owner == OWN_D);
      end
      default: ;
    endcase
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;
  assign if_rsp_data  = if_data_q;
  assign if_rsp_fault = if_flt_q;
  assign d_rsp_data   = d_data_q;
  assign d_rsp_fault  = d_flt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 has MEM_LAT=1, instance 1 MEM_LAT=3,
// each attached to a small behavioural RAM that applies byte-lane selection and extension.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    int          inst;
    bit          own;   // 0 = fetch, 1 = data
    logic [31:0] data;
    logic        flt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        if_req_valid[2], if_req_ready[2], if_rsp_valid[2], if_rsp_fault[2];
  logic [31:0] if_req_addr[2], if_rsp_data[2];
  logic        d_req_valid[2], d_req_ready[2], d_req_we[2], d_rsp_valid[2], d_rsp_fault[2];
  logic [9:0]  d_req_funct[2], m_funct[2];
  logic [31:0] d_req_addr[2], d_req_wdata[2], d_rsp_data[2];
  logic        m_r_en[2], m_w_en[2];
  logic [31:0] m_addr[2], m_wdata[2];

  exp_t exp_q[$];
  int   n_err = 0, n_chk = 0, cyc = 0;
  int   gr_own[16], gr_cyc[16], t0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic rsp_chk(input int g, input bit own, input logic [31:0] data, input logic flt);
    exp_t e;
    check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rsp_inst",  32'(g),   32'(e.inst));
      check("rsp_owner", 32'(own), 32'(e.own));
      check("rsp_data",  data,     e.data);
      check("rsp_fault", 32'(flt), 32'(e.flt));
      check("rsp_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
`ifdef MEM_ARB_ADDR_CHECK_EN
    return a[31:27] != 5'b10000;
`else
    return 1'b0;
`endif
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [1024];
    logic [31:0] rd, wrd, sh;
    int ren = 0, wen = 0;

    mem_port_arbiter #(.MEM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid[g]), .if_req_ready(if_req_ready[g]), .if_req_addr(if_req_addr[g]),
      .if_rsp_valid(if_rsp_valid[g]), .if_rsp_data(if_rsp_data[g]), .if_rsp_fault(if_rsp_fault[g]),
      .d_req_valid(d_req_valid[g]), .d_req_ready(d_req_ready[g]), .d_req_we(d_req_we[g]),
      .d_req_funct(d_req_funct[g]), .d_req_addr(d_req_addr[g]), .d_req_wdata(d_req_wdata[g]),
      .d_rsp_valid(d_rsp_valid[g]), .d_rsp_data(d_rsp_data[g]), .d_rsp_fault(d_rsp_fault[g]),
      .m_r_en(m_r_en[g]), .m_w_en(m_w_en[g]), .m_funct(m_funct[g]), .m_addr(m_addr[g]),
      .m_wdata(m_wdata[g]), .m_rdata(rd)
    );

    always_comb begin
      wrd = mem[m_addr[g][11:2]];
      sh  = wrd >> {m_addr[g][1:0], 3'b000};
      case (m_funct[g])
        FUNC_LB:  rd = {{24{sh[7]}}, sh[7:0]};
        FUNC_LBU: rd = {24'h0, sh[7:0]};
        FUNC_LH:  rd = {{16{sh[15]}}, sh[15:0]};
        FUNC_LHU: rd = {16'h0, sh[15:0]};
        default:  rd = wrd;
      endcase
    end

    always @(posedge clk) if (m_w_en[g]) begin
      case (m_funct[g])
        FUNC_SB: mem[m_addr[g][11:2]][{m_addr[g][1:0], 3'b000} +: 8] <= m_wdata[g][7:0];
        FUNC_SH: mem[m_addr[g][11:2]][{m_addr[g][1], 4'b0000} +: 16] <= m_wdata[g][15:0];
        default: mem[m_addr[g][11:2]] <= m_wdata[g];
      endcase
    end

    always @(negedge clk) begin
      if (m_r_en[g]) ren++;
      if (m_w_en[g]) wen++;
      if (if_rsp_valid[g]) rsp_chk(g, 1'b0, if_rsp_data[g], if_rsp_fault[g]);
      if (d_rsp_valid[g])  rsp_chk(g, 1'b1, d_rsp_data[g], d_rsp_fault[g]);
    end
  end

  function automatic int get_ren(input int i);
    return (i == 0) ? g_dut[0].ren : g_dut[1].ren;
  endfunction
  function automatic int get_wen(input int i);
    return (i == 0) ? g_dut[0].wen : g_dut[1].wen;
  endfunction

  // Holds the given requests valid until n grants are seen, queueing expected responses
  task automatic run(input int i, input bit ifv, input bit dv, input bit we, input logic [9:0] fn,
                     input logic [31:0] daddr, input logic [31:0] wd, input logic [31:0] iaddr,
                     input logic [31:0] exp_if, input logic [31:0] exp_d, input int n);
    int k = 0;
    int lat = (i == 0) ? 1 : 3;
    @(posedge clk); #1;
    if_req_valid[i] = ifv; if_req_addr[i] = iaddr;
    d_req_valid[i] = dv; d_req_we[i] = we; d_req_funct[i] = fn;
    d_req_addr[i] = daddr; d_req_wdata[i] = wd;
    t0 = cyc;
    for (int c = 0; c < 200 && k < n; c++) begin
      @(negedge clk);
      if (if_req_ready[i]) begin
        exp_q.push_back('{inst: i, own: 1'b0, data: bad(iaddr) ? 32'h0 : exp_if,
                          flt: bad(iaddr), cyc: cyc + lat + 1});
        gr_own[k] = 0; gr_cyc[k] = cyc; k++;
      end else if (d_req_ready[i]) begin
        exp_q.push_back('{inst: i, own: 1'b1, data: bad(daddr) ? 32'h0 : exp_d,
                          flt: bad(daddr), cyc: cyc + lat + 1});
        gr_own[k] = 1; gr_cyc[k] = cyc; k++;
      end
    end
    check("grant_count", 32'(k), 32'(n));
    @(posedge clk); #1;
    if_req_valid[i] = 1'b0; d_req_valid[i] = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(negedge clk); #1;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r0, w0;
    bit [9:0] exp_ord;
    for (int i = 0; i < 2; i++) begin
      if_req_valid[i] = 1'b1; if_req_addr[i] = 32'h8000_0000;
      d_req_valid[i] = 1'b1; d_req_we[i] = 1'b1; d_req_funct[i] = FUNC_SW;
      d_req_addr[i] = 32'h8000_0000; d_req_wdata[i] = 32'hFFFF_FFFF;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_if_ready", 32'(if_req_ready[0]), 0);
    check("rst_d_ready",  32'(d_req_ready[0]), 0);
    check("rst_r_en",     32'(m_r_en[0]), 0);
    check("rst_w_en",     32'(m_w_en[1]), 0);
    check("rst_addr",     m_addr[0], 0);
    check("rst_if_rsp",   32'(if_rsp_valid[0]), 0);
    check("rst_d_rsp",    32'(d_rsp_valid[1]), 0);
    check("rst_d_data",   d_rsp_data[0], 0);
    for (int i = 0; i < 2; i++) begin
      if_req_valid[i] = 1'b0; d_req_valid[i] = 1'b0;
    end
    @(negedge clk); #1 rst_n = 1'b1;

    // MEM_LAT=1: store an instruction word, then fetch it
    run(0, 0, 1, 1, FUNC_SW, 32'h8000_0000, 32'h0000_0013, 0, 0, 0, 1);
    run(0, 1, 0, 0, FUNC_LW, 0, 0, 32'h8000_0000, 32'h0000_0013, 0, 1);
    check("if_zero_lat_accept", 32'(gr_cyc[0]), 32'(t0));

    w0 = get_wen(0);
    run(0, 0, 1, 1, FUNC_SB, 32'h8000_0101, 32'h1234_5678, 0, 0, 0, 1);
    check("sb_single_wen", 32'(get_wen(0) - w0), 1);
    run(0, 0, 1, 0, FUNC_LBU, 32'h8000_0101, 0, 0, 0, 32'h0000_0078, 1);
    run(0, 0, 1, 1, FUNC_SB, 32'h8000_0102, 32'h0000_0080, 0, 0, 0, 1);
    run(0, 0, 1, 0, FUNC_LB, 32'h8000_0102, 0, 0, 0, 32'hFFFF_FF80, 1);

    // Both held valid: fetch wins after four consecutive losses
    run(0, 1, 1, 0, FUNC_LBU, 32'h8000_0101, 0, 32'h8000_0000, 32'h0000_0013, 32'h0000_0078, 10);
    exp_ord = 10'b0111101111;
    for (int k = 0; k < 10; k++) check($sformatf("grant_order_%0d", k), 32'(gr_own[k]), 32'(exp_ord[k]));

    // MEM_LAT=3
    run(1, 0, 1, 1, FUNC_SW, 32'h8000_0010, 32'hCAFE_F00D, 0, 0, 0, 1);
    r0 = get_ren(1);
    run(1, 0, 1, 0, FUNC_LW, 32'h8000_0010, 0, 0, 0, 32'hCAFE_F00D, 1);
    check("lat3_r_en_cycles", 32'(get_ren(1) - r0), 3);
    run(1, 0, 1, 0, FUNC_LW, 32'h8000_0010, 0, 0, 0, 32'hCAFE_F00D, 2);
    check("lat3_back_to_back", 32'(gr_cyc[1] - gr_cyc[0]), 5);

    // Reset during the write beat of a store
    @(posedge clk); #1;
    d_req_valid[1] = 1'b1; d_req_we[1] = 1'b1; d_req_funct[1] = FUNC_SW;
    d_req_addr[1] = 32'h8000_0020; d_req_wdata[1] = 32'h5555_5555;
    @(negedge clk);
    check("rstbusy_accept", 32'(d_req_ready[1]), 1);
    @(posedge clk); #1 d_req_valid[1] = 1'b0;
    @(negedge clk);
    check("rstbusy_wen_before", 32'(m_w_en[1]), 1);
    #1 rst_n = 1'b0;
    #1 check("rstbusy_wen_async", 32'(m_w_en[1]), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run(1, 0, 1, 0, FUNC_LW, 32'h8000_0010, 0, 0, 0, 32'hCAFE_F00D, 1);
    check("rstbusy_new_accept", 32'(gr_cyc[0]), 32'(t0));

`ifdef MEM_ARB_ADDR_CHECK_EN
    r0 = get_ren(1);
    run(1, 0, 1, 0, FUNC_LW, 32'h0000_1000, 0, 0, 0, 32'h1111_1111, 1);
    check("fault_no_r_en", 32'(get_ren(1) - r0), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (IF) and load/store (D). The memory port is the DPI-backed RAM with its r_en/w_en/funct/addr/wdata/rdata interface.
- Sits between the pipeline's fetch/MEM stages and the RAM.
- Serialises one access at a time with a fixed-latency counter and returns responses over valid-only channels.
- Guarantees each store reaches the RAM as exactly one write-enable cycle.

Parameters:
- MEM_LAT, 1, cycles in BUSY before read data is sampled; legal range 1..15.
- STARVE_MAX, 4, consecutive IF losses after which IF wins the next arbitration.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  32  fetch address; always a word read (FUNC_LW)
- if_rsp_valid  out  1  one-cycle fetch response strobe
- if_rsp_data  out  32  instruction word
- if_rsp_fault  out  1  address fault, qualified by if_rsp_valid
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = store, 0 = load
- d_req_funct  in  10  FUNC_* code (LB/LH/LW/LBU/LHU/SB/SH/SW)
- d_req_addr  in  32  data address
- d_req_wdata  in  32  store data
- d_rsp_valid  out  1  one-cycle data response strobe; issued for stores too
- d_rsp_data  out  32  load result; 0 for stores
- d_rsp_fault  out  1  address fault, qualified by d_rsp_valid
- m_r_en  out  1  RAM read enable
- m_w_en  out  1  RAM write enable
- m_funct  out  10  RAM funct
- m_addr  out  32  RAM address
- m_wdata  out  32  RAM write data
- m_rdata  in  32  RAM read data (combinational from m_addr)

Behaviour:
- State machine: IDLE, BUSY, RESP.
- Reset (async, rst_n=0): state=IDLE; all outputs 0; latched request, beat counter, starve counter and owner cleared. A reset mid-BUSY abandons the access: no response is issued, and m_w_en drops immediately.
- IDLE arbitration, decided combinationally each cycle:
  - Only D valid: D wins.
  - Only IF valid: IF wins.
  - Both valid: D wins unless starve_cnt==STARVE_MAX, in which case IF wins.
- The ready of the winner is asserted in the same cycle as its valid (zero-latency accept). The loser's ready stays 0.
- On accept, latch owner, addr, funct (FUNC_LW for IF), we and wdata. Load beat counter with MEM_LAT-1 and go to BUSY.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when IF is valid and loses.
  - Clears when IF is accepted.
  - Unchanged otherwise.
- Readies are 0 in BUSY and RESP.
- BUSY:
  - m_addr, m_funct and m_wdata are driven from the latched values.
  - m_r_en=1 for every BUSY cycle of a load or fetch.
  - m_w_en=1 only in the first BUSY cycle of a store, so exactly one RAM write edge occurs.
  - Beat counter decrements each cycle. When it is 0, capture m_rdata into the response register and go to RESP.
- RESP: owner's rsp_valid=1 for exactly one cycle with data and fault; then IDLE. All m_* outputs are 0 outside BUSY.
- Latency: a request accepted in cycle N responds in cycle N+MEM_LAT+1. A new request can be accepted in cycle N+MEM_LAT+2.
- rsp_data and rsp_fault hold their last value between strobes; consumers must qualify them with rsp_valid.
- Sign extension and byte-lane selection are done by the RAM per funct. The arbiter passes data through unchanged.

Optional Feature:
- Macro MEM_ARB_ADDR_CHECK_EN. When defined, an address outside 0x80000000..0x87FFFFFF sets fault at accept time.
- A faulting access still passes through BUSY and RESP with unchanged timing, but m_r_en and m_w_en stay 0. It responds with rsp_data=0 and rsp_fault=1.
- When the macro is undefined, the fault ports are tied to 0 and every address is forwarded.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding (IDLE/BUSY/RESP).
  - Owner IDs (OWN_IF=0, OWN_D=1).
  - Legal RAM window constants MEM_BASE=0x80000000 and MEM_TOP=0x87FFFFFF.
- FUNC_* codes stay in the existing shared define header.
- One natural sub-module, mem_arb_pick: combinational winner selection plus the saturating starve counter.

Test Plan:
- MEM_LAT=1, IF only, addr 0x80000000 holding 0x00000013: if_req_ready same cycle; if_rsp_valid 2 cycles later with 0x00000013; d_rsp_valid stays 0.
- D store SB addr 0x80000101, wdata 0x12345678: m_w_en high for exactly 1 cycle; then LBU at the same address returns d_rsp_data 0x00000078, and LB of byte 0x80 returns 0xFFFFFF80.
- IF and D both held valid continuously with STARVE_MAX=4: grant order D,D,D,D,IF,D,...; starve_cnt returns to 0 after the IF grant.
- MEM_LAT=3, LW: m_r_en high for 3 cycles; response 4 cycles after accept; next accept 5 cycles after the first.
- rst_n pulled low during BUSY of a store with MEM_LAT=3: m_w_en drops asynchronously; no rsp_valid; after release, state is IDLE and a new request is accepted.
- MEM_ARB_ADDR_CHECK_EN defined, LW addr 0x00001000: m_r_en never asserts; d_rsp_valid with d_rsp_fault=1 and data 0.
